// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: Stall*/Flush* are 0-cycle combinational from state and inputs, and the pipeline freezes while data memory is busy.
// Branch flushes that arrive during a wait are replayed in REDIRECT. HAZARD_CTRL_PERF_EN enables the saturating perf counters.
module hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] RdE,
    input  logic                      LoadE,
    input  logic                      PCSrcE,
    input  logic                      MemReqM,
    input  logic                      MemReadyM,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      StallE,
    output logic                      StallM,
    output logic                      FlushD,
    output logic                      FlushE,
    output logic                      FlushW,
    output logic                      TimeoutErr,
    output logic [1:0]                StateO,
    output logic [CNT_WIDTH-1:0]      StallCycles,
    output logic [CNT_WIDTH-1:0]      FlushCount
);
    localparam int WC_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              pend_flush_q, pend_flush_d;
    logic              timeout_err_q, timeout_err_d;

    logic load_use, mem_wait, timeout_hit;
    logic sf, sd, se, sm, fd, fe, fw;

    assign load_use    = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign mem_wait    = MemReqM && !MemReadyM;
    assign timeout_hit = (state_q == ST_MEM_WAIT) && !MemReadyM &&
                         (wait_cnt_q == WC_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            pend_flush_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            pend_flush_q  <= pend_flush_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d       = ST_RUN;
        wait_cnt_d    = wait_cnt_q;
        pend_flush_d  = 1'b0;
        timeout_err_d = timeout_err_q;
        case (state_q)
            ST_RUN: begin
                if (mem_wait) begin
                    state_d      = ST_MEM_WAIT;
                    wait_cnt_d   = '0;
                    pend_flush_d = PCSrcE;
                end
            end
            ST_MEM_WAIT: begin
                if (MemReadyM) begin
                    // a branch on the completing cycle still needs its redirect
                    state_d = (pend_flush_q || PCSrcE) ? ST_REDIRECT : ST_RUN;
                end else if (timeout_hit) begin
                    timeout_err_d = 1'b1;
                end else begin
                    state_d      = ST_MEM_WAIT;
                    wait_cnt_d   = wait_cnt_q + WC_W'(1);
                    pend_flush_d = pend_flush_q || PCSrcE;
                end
            end
            ST_REDIRECT: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        sf = 1'b0; sd = 1'b0; se = 1'b0; sm = 1'b0;
        fd = 1'b0; fe = 1'b0; fw = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mem_wait) begin
                    {sf, sd, se, sm, fw} = 5'b11111;
                end else if (PCSrcE) begin
                    fd = 1'b1;
                    fe = 1'b1;
                end else if (load_use) begin
                    sf = 1'b1;
                    sd = 1'b1;
                    fe = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (timeout_hit) begin
                    fd = 1'b1;
                    fe = 1'b1;
                end else if (!MemReadyM) begin
                    {sf, sd, se, sm, fw} = 5'b11111;
                end
            end
            ST_REDIRECT: begin
                fd = 1'b1;
                fe = 1'b1;
            end
            default: begin
                sf = 1'b0;
            end
        endcase
    end

    // outputs are forced quiet while reset is held, whatever the inputs do
    assign StallF     = sf && rst_n;
    assign StallD     = sd && rst_n;
    assign StallE     = se && rst_n;
    assign StallM     = sm && rst_n;
    assign FlushD     = fd && rst_n;
    assign FlushE     = fe && rst_n;
    assign FlushW     = fw && rst_n;
    assign TimeoutErr = timeout_err_q;
    assign StateO     = state_q;

`ifdef HAZARD_CTRL_PERF_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (StallF && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
            if (FlushE && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign StallCycles = stall_cnt_q;
    assign FlushCount  = flush_cnt_q;
`else
    assign StallCycles = '0;
    assign FlushCount  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: cycle-by-cycle vector table plus reset and timeout sequences.
module tb_hazard_ctrl;
    logic        clk;
    logic        rst_n;
    logic [4:0]  Rs1D, Rs2D, RdE;
    logic        LoadE, PCSrcE, MemReqM, MemReadyM;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, TimeoutErr;
    logic [1:0]  StateO;
    logic [31:0] StallCycles, FlushCount;

    int checks = 0;
    int failures = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    hazard_ctrl #(
        .REG_ADDR_WIDTH(5),
        .TIMEOUT_CYCLES(4),
        .CNT_WIDTH(32)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE),
        .LoadE(LoadE), .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .TimeoutErr(TimeoutErr), .StateO(StateO),
        .StallCycles(StallCycles), .FlushCount(FlushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    logic [6:0] outs;
    assign outs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

    typedef struct {
        string      nm;
        logic [4:0] rs1, rs2, rd;
        logic       ld, pc, req, rdy;
        logic [6:0] exp_o;
        logic [1:0] exp_st;
    } vec_t;

    vec_t tbl[$];

    localparam logic [6:0] O_NONE  = 7'b0000000;
    localparam logic [6:0] O_LU    = 7'b1100010;
    localparam logic [6:0] O_BR    = 7'b0000110;
    localparam logic [6:0] O_FRZ   = 7'b1111001;

    task automatic add(input string nm, input logic [4:0] rs1, rs2, rd,
                       input logic ld, pc, req, rdy,
                       input logic [6:0] eo, input logic [1:0] es);
        vec_t v;
        v.nm = nm; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.ld = ld; v.pc = pc; v.req = req; v.rdy = rdy;
        v.exp_o = eo; v.exp_st = es;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, rs2, rd, input logic ld, pc, req, rdy);
        Rs1D = rs1; Rs2D = rs2; RdE = rd;
        LoadE = ld; PCSrcE = pc; MemReqM = req; MemReadyM = rdy;
    endtask

    // inputs change just after the rising edge, outputs are sampled on the falling edge
    task automatic cycle(input logic [4:0] rs1, rs2, rd, input logic ld, pc, req, rdy);
        @(posedge clk);
        #1;
        drive(rs1, rs2, rd, ld, pc, req, rdy);
        @(negedge clk);
    endtask

    task automatic chk_cycle(input string nm, input logic [6:0] eo, input logic [1:0] es,
                             input logic eterr);
        chk({nm, ".outs"}, {25'd0, outs}, {25'd0, eo});
        chk({nm, ".state"}, {30'd0, StateO}, {30'd0, es});
        chk({nm, ".terr"}, {31'd0, TimeoutErr}, {31'd0, eterr});
    endtask

    initial begin
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        //            name          rs1 rs2 rd  ld pc rq rdy  outs    state
        add("idle_nomatch",  5'd1, 5'd2, 5'd3, 1, 0, 0, 0, O_NONE, 2'd0);
        add("lu_rs1",        5'd5, 5'd2, 5'd5, 1, 0, 0, 0, O_LU,   2'd0);
        add("lu_rs2",        5'd1, 5'd7, 5'd7, 1, 0, 0, 0, O_LU,   2'd0);
        add("lu_rd0",        5'd0, 5'd0, 5'd0, 1, 0, 0, 0, O_NONE, 2'd0);
        add("match_noload",  5'd5, 5'd2, 5'd5, 0, 0, 0, 0, O_NONE, 2'd0);
        add("br_over_lu",    5'd5, 5'd2, 5'd5, 1, 1, 0, 0, O_BR,   2'd0);
        add("br_alone",      5'd1, 5'd2, 5'd3, 0, 1, 0, 0, O_BR,   2'd0);
        add("req_ready_run", 5'd1, 5'd2, 5'd3, 0, 0, 1, 1, O_NONE, 2'd0);
        add("mw1_over_lu",   5'd5, 5'd2, 5'd5, 1, 0, 1, 0, O_FRZ,  2'd0);
        add("mw2",           5'd0, 5'd0, 5'd0, 0, 0, 1, 0, O_FRZ,  2'd1);
        add("mw3",           5'd0, 5'd0, 5'd0, 0, 0, 1, 0, O_FRZ,  2'd1);
        add("mw_ready",      5'd0, 5'd0, 5'd0, 0, 0, 1, 1, O_NONE, 2'd1);
        add("mw_back_run",   5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_NONE, 2'd0);
        add("bw_c1",         5'd0, 5'd0, 5'd0, 0, 0, 1, 0, O_FRZ,  2'd0);
        add("bw_c2_branch",  5'd0, 5'd0, 5'd0, 0, 1, 1, 0, O_FRZ,  2'd1);
        add("bw_c3",         5'd0, 5'd0, 5'd0, 0, 0, 1, 0, O_FRZ,  2'd1);
        add("bw_c4",         5'd0, 5'd0, 5'd0, 0, 0, 1, 0, O_FRZ,  2'd1);
        add("bw_ready_edge", 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, O_NONE, 2'd1);
        add("bw_redirect",   5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_BR,   2'd2);
        add("bw_run",        5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_NONE, 2'd0);
        add("br_at_entry",   5'd0, 5'd0, 5'd0, 0, 1, 1, 0, O_FRZ,  2'd0);
        add("be_ready",      5'd0, 5'd0, 5'd0, 0, 0, 1, 1, O_NONE, 2'd1);
        add("be_redir_newbr",5'd5, 5'd0, 5'd5, 1, 1, 0, 0, O_BR,   2'd2);
        add("be_run",        5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_NONE, 2'd0);
        add("br_on_ready_c1",5'd0, 5'd0, 5'd0, 0, 0, 1, 0, O_FRZ,  2'd0);
        add("br_on_ready",   5'd0, 5'd0, 5'd0, 0, 1, 1, 1, O_NONE, 2'd1);
        add("bor_redirect",  5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_BR,   2'd2);
        add("bor_run",       5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_NONE, 2'd0);

        // reset held with hazards present on the inputs: outputs must stay quiet
        rst_n = 1'b0;
        drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        #7;
        chk_cycle("in_reset", O_NONE, 2'd0, 1'b0);
        @(negedge clk);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            cycle(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].ld, tbl[i].pc, tbl[i].req, tbl[i].rdy);
            chk_cycle(tbl[i].nm, tbl[i].exp_o, tbl[i].exp_st, 1'b0);
            if (tbl[i].exp_o[6]) exp_stall++;
            if (tbl[i].exp_o[1]) exp_flush++;
        end

`ifdef HAZARD_CTRL_PERF_EN
        chk("tbl.stall_cycles", StallCycles, exp_stall);
        chk("tbl.flush_count", FlushCount, exp_flush);
`else
        chk("tbl.stall_cycles", StallCycles, 32'd0);
        chk("tbl.flush_count", FlushCount, 32'd0);
`endif

        // asynchronous reset in the middle of a memory wait
        cycle(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_cycle("rst_mw1", O_FRZ, 2'd0, 1'b0);
        cycle(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_cycle("rst_mw2", O_FRZ, 2'd1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_cycle("rst_async", O_NONE, 2'd0, 1'b0);
        chk("rst_stall_cycles", StallCycles, 32'd0);
        @(posedge clk);
        @(negedge clk);
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        cycle(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 0, 0);
        chk_cycle("rst_release", O_NONE, 2'd0, 1'b0);

        // timeout: TIMEOUT_CYCLES=4, ready never arrives
        cycle(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_cycle("to_c1", O_FRZ, 2'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            chk_cycle("to_wait", O_FRZ, 2'd1, 1'b0);
        end
        cycle(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_cycle("to_abort", O_BR, 2'd1, 1'b0);
        cycle(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cycle("to_after", O_NONE, 2'd0, 1'b1);
`ifdef HAZARD_CTRL_PERF_EN
        chk("to.stall_cycles", StallCycles, 32'd4);
        chk("to.flush_count", FlushCount, 32'd1);
`else
        chk("to.stall_cycles", StallCycles, 32'd0);
        chk("to.flush_count", FlushCount, 32'd0);
`endif

        // sticky through a normal wait and normal operation
        cycle(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_cycle("sticky_mw", O_FRZ, 2'd0, 1'b1);
        cycle(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_cycle("sticky_ready", O_NONE, 2'd1, 1'b1);
        cycle(5'd3, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_cycle("sticky_lu", O_LU, 2'd0, 1'b1);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("terr_cleared", {31'd0, TimeoutErr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
